// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID register: holds the PC, issues I-cache word reads,
// absorbs cache/downstream stalls and applies delay-slot redirects from ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ICACHE_ren_o,
  output logic [29:0] ICACHE_addr_o,
  input  logic        ICACHE_stall_i,
  input  logic [31:0] ICACHE_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pco_q, pco_d;
  logic        valid_q, valid_d;

  logic        complete;
  logic [31:0] next_pc;

  // Request is a pure decode of the state so it falls with an asynchronous reset.
  assign ICACHE_ren_o  = (state_q == S_FETCH);
  assign ICACHE_addr_o = pc_q[31:2];
  assign instruction_o = instr_q;
  assign pc_o          = pco_q;
  assign valid_o       = valid_q;

  assign complete = ICACHE_ren_o && !ICACHE_stall_i;
  assign next_pc  = redirect_i ? redirect_pc_i :
                    pend_q     ? pend_pc_q     : pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pco_d        = pco_q;
    valid_d      = valid_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (!stall_i) begin
          instr_d = 32'd0;
          pco_d   = 32'd0;
          valid_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (complete) begin
          pc_d   = next_pc;
          pend_d = 1'b0;
          if (!stall_i) begin
            instr_d = ICACHE_rdata_i;
            pco_d   = pc_q;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = ICACHE_rdata_i;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end else if (!stall_i) begin
          instr_d = 32'd0;
          pco_d   = 32'd0;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          instr_d = skid_instr_q;
          pco_d   = skid_pc_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase

    // A redirect with no completing fetch waits for the in-flight one (the delay slot).
    if (redirect_i && !complete) begin
      pend_d    = 1'b1;
      pend_pc_d = redirect_pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      instr_q      <= 32'd0;
      pco_q        <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pco_q        <= pco_d;
      valid_q      <= valid_d;
    end
  end

endmodule
